// File: rtl/vga_scanout.sv
// Parametrised VGA scanout: H/V timing, scaled framebuffer reads, latency-matched RGB332/sync/blank output.
// Optional VGA_SCANOUT_BORDER_EN adds a border_color port that overrides pixels near the active-area edges.
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SCALE_LOG2 = 1,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int BPP        = 1,
    parameter int RD_LAT     = 1,
    parameter int BORDER_PX  = 8
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] x_a,
    output logic [Y_W-1:0] y_a,
    input  logic [BPP-1:0] in_a,
    input  logic [7:0]     fg_color,
    input  logic [7:0]     bg_color,
`ifdef VGA_SCANOUT_BORDER_EN
    input  logic [7:0]     border_color,
`endif
    output logic           HS,
    output logic           VS,
    output logic [2:0]     R,
    output logic [2:0]     G,
    output logic [1:0]     B,
    output logic           blank,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT   = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_LAST = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT   = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_LAST = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (BPP != 1 && BPP != 8) begin : g_bad_bpp
        $error("vga_scanout: BPP must be 1 or 8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("vga_scanout: RD_LAT must be 1..4");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
        $error("vga_scanout: SCALE_LOG2 must be 0..3");
    end
    if (((H_ACTIVE - 1) >> SCALE_LOG2) >= (1 << X_W) ||
        ((V_ACTIVE - 1) >> SCALE_LOG2) >= (1 << Y_W)) begin : g_bad_aw
        $error("vga_scanout: X_W/Y_W too small for scaled active area");
    end
    if (2 * BORDER_PX > H_ACTIVE || 2 * BORDER_PX > V_ACTIVE) begin : g_bad_border
        $error("vga_scanout: BORDER_PX too large for active area");
    end

    logic [HC_W-1:0] hcnt, hnext;
    logic [VC_W-1:0] vcnt, vnext;
    logic            act_next;
    logic            act_cur, hs_cur, vs_cur, fs_cur;

    always_comb begin
        hnext = hcnt + 1'b1;
        vnext = vcnt;
        if (hcnt == H_LAST) begin
            hnext = '0;
            vnext = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        act_next = (hnext < H_ACT) && (vnext < V_ACT);
        act_cur  = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_cur   = (hcnt >= HS_BEG) && (hcnt <= HS_LAST);
        vs_cur   = (vcnt >= VS_BEG) && (vcnt <= VS_LAST);
        fs_cur   = (hcnt == '0) && (vcnt == '0);
    end

    // Flag pipes: element RD_LAT-1 lines up with the read data on in_a.
    logic [RD_LAT-1:0] act_p, hs_p, vs_p, fs_p;
    logic [7:0]        fb_color, pix;

    if (BPP == 8) begin : g_bpp8
        assign fb_color = in_a[7:0];
    end else begin : g_bpp1
        assign fb_color = in_a[0] ? fg_color : bg_color;
    end

`ifdef VGA_SCANOUT_BORDER_EN
    localparam logic [HC_W-1:0] BH_LO = HC_W'(BORDER_PX);
    localparam logic [HC_W-1:0] BH_HI = HC_W'(H_ACTIVE - BORDER_PX);
    localparam logic [VC_W-1:0] BV_LO = VC_W'(BORDER_PX);
    localparam logic [VC_W-1:0] BV_HI = VC_W'(V_ACTIVE - BORDER_PX);

    logic              bdr_cur;
    logic [RD_LAT-1:0] bdr_p;

    assign bdr_cur = (hcnt < BH_LO) || (hcnt >= BH_HI) || (vcnt < BV_LO) || (vcnt >= BV_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            bdr_p <= '0;
        end else begin
            bdr_p[0] <= bdr_cur;
            for (int i = 1; i < RD_LAT; i++) bdr_p[i] <= bdr_p[i-1];
        end
    end

    always_comb begin
        pix = 8'h00;
        if (act_p[RD_LAT-1]) pix = bdr_p[RD_LAT-1] ? border_color : fb_color;
    end
`else
    always_comb begin
        pix = 8'h00;
        if (act_p[RD_LAT-1]) pix = fb_color;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            x_a         <= '0;
            y_a         <= '0;
            act_p       <= '0;
            hs_p        <= '0;
            vs_p        <= '0;
            fs_p        <= '0;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hcnt <= hnext;
            vcnt <= vnext;
            // Address is built from the next count so x_a/y_a stay aligned with hcnt/vcnt.
            x_a  <= act_next ? X_W'(hnext >> SCALE_LOG2) : '0;
            y_a  <= act_next ? Y_W'(vnext >> SCALE_LOG2) : '0;

            act_p[0] <= act_cur;
            hs_p[0]  <= hs_cur;
            vs_p[0]  <= vs_cur;
            fs_p[0]  <= fs_cur;
            for (int i = 1; i < RD_LAT; i++) begin
                act_p[i] <= act_p[i-1];
                hs_p[i]  <= hs_p[i-1];
                vs_p[i]  <= vs_p[i-1];
                fs_p[i]  <= fs_p[i-1];
            end

            HS          <= hs_p[RD_LAT-1] ? HS_POL : ~HS_POL;
            VS          <= vs_p[RD_LAT-1] ? VS_POL : ~VS_POL;
            R           <= pix[7:5];
            G           <= pix[4:2];
            B           <= pix[1:0];
            blank       <= ~act_p[RD_LAT-1];
            frame_start <= fs_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default, RD_LAT=3/BPP=8 and tiny-timing instances checked against an arithmetic screen model.
// Honours VGA_SCANOUT_BORDER_EN for the border_color port and the expected colours.
module tb_vga_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic rst_d = 1'b1, rst_l = 1'b1, rst_s = 1'b1;
    logic [7:0] fg = 8'h00, bg = 8'h00;
`ifdef VGA_SCANOUT_BORDER_EN
    logic [7:0] bc = 8'h1C;
`endif

    logic [8:0] x_d, x_l, x_s;
    logic [7:0] y_d, y_l, y_s;
    logic       in_d = 1'b0, in_s = 1'b0;
    logic [7:0] in_l = 8'h00, l1 = 8'h00, l2 = 8'h00;
    logic       hs_d, vs_d, blank_d, fs_d, hs_l, vs_l, blank_l, fs_l, hs_s, vs_s, blank_s, fs_s;
    logic [2:0] r_d, g_d, r_l, g_l, r_s, g_s;
    logic [1:0] b_d, b_l, b_s;

    logic mem_d [8][320];
    logic mem_s [4][8];

    vga_scanout u_def (
        .clk(clk), .rst(rst_d), .x_a(x_d), .y_a(y_d), .in_a(in_d),
        .fg_color(fg), .bg_color(bg),
`ifdef VGA_SCANOUT_BORDER_EN
        .border_color(bc),
`endif
        .HS(hs_d), .VS(vs_d), .R(r_d), .G(g_d), .B(b_d), .blank(blank_d), .frame_start(fs_d)
    );

    vga_scanout #(.RD_LAT(3), .BPP(8)) u_l3 (
        .clk(clk), .rst(rst_l), .x_a(x_l), .y_a(y_l), .in_a(in_l),
        .fg_color(fg), .bg_color(bg),
`ifdef VGA_SCANOUT_BORDER_EN
        .border_color(bc),
`endif
        .HS(hs_l), .VS(vs_l), .R(r_l), .G(g_l), .B(b_l), .blank(blank_l), .frame_start(fs_l)
    );

    vga_scanout #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .SCALE_LOG2(0), .HS_POL(1'b1), .BORDER_PX(1)) u_sm (
        .clk(clk), .rst(rst_s), .x_a(x_s), .y_a(y_s), .in_a(in_s),
        .fg_color(fg), .bg_color(bg),
`ifdef VGA_SCANOUT_BORDER_EN
        .border_color(bc),
`endif
        .HS(hs_s), .VS(vs_s), .R(r_s), .G(g_s), .B(b_s), .blank(blank_s), .frame_start(fs_s)
    );

    // Framebuffer RAM models
    always @(posedge clk) in_d <= (x_d < 9'd320) ? mem_d[y_d[2:0]][x_d] : 1'b0;
    always @(posedge clk) begin
        l1   <= x_l[7:0];
        l2   <= l1;
        in_l <= l2;
    end
    always @(posedge clk) in_s <= (x_s < 9'd8 && y_s < 8'd4) ? mem_s[y_s[1:0]][x_s[2:0]] : 1'b0;

    // Screen model: p is the counter position the output shows; p<0 means still inside the reset flush.
    function automatic logic [3:0] exp_tim(int p, int ha, int hf, int hsw, int hbp,
                                           int va, int vf, int vsw, int vbp, bit hpol, bit vpol);
        int  htot, vtot, h, v;
        logic act, hs, vs;
        if (p < 0) return {1'b1, ~hpol, ~vpol, 1'b0};
        htot = ha + hf + hsw + hbp;
        vtot = va + vf + vsw + vbp;
        h = p % htot;
        v = (p / htot) % vtot;
        act = (h < ha) && (v < va);
        hs  = (h >= ha + hf && h < ha + hf + hsw) ? hpol : ~hpol;
        vs  = (v >= va + vf && v < va + vf + vsw) ? vpol : ~vpol;
        return {~act, hs, vs, (h == 0 && v == 0)};
    endfunction

    function automatic logic [11:0] exp_d(int p);
        int h, v;
        logic [7:0] col;
        col = 8'h00;
        if (p >= 0) begin
            h = p % 800;
            v = (p / 800) % 525;
            if (h < 640 && v < 480) begin
                col = mem_d[(v / 2) % 8][h / 2] ? fg : bg;
`ifdef VGA_SCANOUT_BORDER_EN
                if (h < 8 || h >= 632 || v < 8 || v >= 472) col = bc;
`endif
            end
        end
        return {col, exp_tim(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)};
    endfunction

    function automatic logic [11:0] exp_l(int p);
        int h, v;
        logic [7:0] col;
        col = 8'h00;
        if (p >= 0) begin
            h = p % 800;
            v = (p / 800) % 525;
            if (h < 640 && v < 480) begin
                col = 8'((h / 2) % 256);
`ifdef VGA_SCANOUT_BORDER_EN
                if (h < 8 || h >= 632 || v < 8 || v >= 472) col = bc;
`endif
            end
        end
        return {col, exp_tim(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)};
    endfunction

    function automatic logic [11:0] exp_s(int p);
        int h, v;
        logic [7:0] col;
        col = 8'h00;
        if (p >= 0) begin
            h = p % 12;
            v = (p / 12) % 7;
            if (h < 8 && v < 4) begin
                col = mem_s[v][h] ? fg : bg;
`ifdef VGA_SCANOUT_BORDER_EN
                if (h < 1 || h >= 7 || v < 1 || v >= 3) col = bc;
`endif
            end
        end
        return {col, exp_tim(p, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0)};
    endfunction

    // Reset pulses: return at the negedge of the first cycle after the reset edge (cycle 0).
    task automatic pulse_rst_d();
        @(negedge clk) rst_d = 1'b1;
        @(negedge clk) rst_d = 1'b0;
    endtask
    task automatic pulse_rst_l();
        @(negedge clk) rst_l = 1'b1;
        @(negedge clk) rst_l = 1'b0;
    endtask
    task automatic pulse_rst_s();
        @(negedge clk) rst_s = 1'b1;
        @(negedge clk) rst_s = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d} !== 12'h00E) begin
                n_fail++;
                $display("FAIL reset_def c=%0d got %0h exp 00e", c, {r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d});
            end
            n_tests++;
            if ({x_d, y_d} !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_addr c=%0d got x=%0d y=%0d exp 0 0", c, x_d, y_d);
            end
            n_tests++;
            if ({r_s, g_s, b_s, blank_s, hs_s, vs_s, fs_s} !== 12'h00A) begin
                n_fail++;
                $display("FAIL reset_small c=%0d got %0h exp 00a", c, {r_s, g_s, b_s, blank_s, hs_s, vs_s, fs_s});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pattern();
        logic [11:0] exp;
        logic        prev_hs;
        int          fall1, fall2, rise1;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 320; x++) mem_d[y][x] = 1'(x ^ y);
        fg = 8'hE0;
        bg = 8'h03;
        fall1 = -1; fall2 = -1; rise1 = -1;
        prev_hs = 1'b1;
        pulse_rst_d();
        for (int c = 0; c <= 2 * 800 + 702; c++) begin
            exp = exp_d(c - 2);
            n_tests++;
            if ({r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d} !== exp) begin
                n_fail++;
                $display("FAIL pat_pixel c=%0d got %0h exp %0h", c, {r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d}, exp);
            end
            if (c == 638 || c == 639) begin
                n_tests++;
                if (x_d !== 9'd319) begin
                    n_fail++;
                    $display("FAIL pat_xa_end c=%0d got %0d exp 319", c, x_d);
                end
            end
            if (c == 700) begin
                n_tests++;
                if (x_d !== 9'd0) begin
                    n_fail++;
                    $display("FAIL pat_xa_blank got %0d exp 0", x_d);
                end
            end
`ifndef VGA_SCANOUT_BORDER_EN
            if (c == 2 || c == 4 || c == 1602) begin
                n_tests++;
                if ({r_d, g_d, b_d} !== ((c == 2) ? 8'h03 : 8'hE0)) begin
                    n_fail++;
                    $display("FAIL pat_fixed c=%0d got %0h exp %0h", c, {r_d, g_d, b_d}, (c == 2) ? 8'h03 : 8'hE0);
                end
            end
`else
            if (c == 9) begin
                n_tests++;
                if ({r_d, g_d, b_d} !== 8'h1C) begin
                    n_fail++;
                    $display("FAIL pat_border got %0h exp 1c", {r_d, g_d, b_d});
                end
            end
`endif
            if (prev_hs && !hs_d) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            if (!prev_hs && hs_d && rise1 < 0) rise1 = c;
            prev_hs = hs_d;
            @(negedge clk);
        end
        n_tests++;
        if (fall1 !== 658) begin
            n_fail++;
            $display("FAIL hs_first_fall got %0d exp 658", fall1);
        end
        n_tests++;
        if (rise1 - fall1 !== 96) begin
            n_fail++;
            $display("FAIL hs_low_width got %0d exp 96", rise1 - fall1);
        end
        n_tests++;
        if (fall2 - fall1 !== 800) begin
            n_fail++;
            $display("FAIL hs_period got %0d exp 800", fall2 - fall1);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 320; x++) mem_d[y][x] = 1'($urandom_range(0, 1));
        fg = 8'($urandom);
        bg = 8'($urandom);
        pulse_rst_d();
        for (int c = 0; c <= 4 * 800 + 10; c++) begin
            exp = exp_d(c - 2);
            n_tests++;
            if ({r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d} !== exp) begin
                n_fail++;
                $display("FAIL rnd_pixel c=%0d got %0h exp %0h", c, {r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] exp;
        pulse_rst_d();
        repeat (2 * 800 + 300) @(negedge clk);
        n_tests++;
        if (x_d !== 9'd150 || blank_d !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_before got x=%0d blank=%0b exp x=150 blank=0", x_d, blank_d);
        end
        rst_d = 1'b1;
        @(negedge clk) rst_d = 1'b0;
        n_tests++;
        if ({r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d, x_d, y_d} !== {12'h00E, 17'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_vals got %0h exp %0h", {r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d, x_d, y_d},
                     {12'h00E, 17'd0});
        end
        for (int c = 0; c <= 900; c++) begin
            exp = exp_d(c - 2);
            n_tests++;
            if ({r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d} !== exp) begin
                n_fail++;
                $display("FAIL mid_pixel c=%0d got %0h exp %0h", c, {r_d, g_d, b_d, blank_d, hs_d, vs_d, fs_d}, exp);
            end
            if (c == 2) begin
                n_tests++;
                if (fs_d !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_frame_start got %0b exp 1", fs_d);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_latency3();
        logic [11:0] exp;
        pulse_rst_l();
        for (int c = 0; c <= 800 + 700; c++) begin
            exp = exp_l(c - 4);
            n_tests++;
            if ({r_l, g_l, b_l, blank_l, hs_l, vs_l, fs_l} !== exp) begin
                n_fail++;
                $display("FAIL lat3_pixel c=%0d got %0h exp %0h", c, {r_l, g_l, b_l, blank_l, hs_l, vs_l, fs_l}, exp);
            end
            if (c == 3 || c == 4) begin
                n_tests++;
                if (fs_l !== (c == 4)) begin
                    n_fail++;
                    $display("FAIL lat3_frame_start c=%0d got %0b exp %0b", c, fs_l, (c == 4));
                end
            end
            if (c == 659 || c == 660) begin
                n_tests++;
                if (hs_l !== (c == 659)) begin
                    n_fail++;
                    $display("FAIL lat3_hs c=%0d got %0b exp %0b", c, hs_l, (c == 659));
                end
            end
`ifndef VGA_SCANOUT_BORDER_EN
            if (c == 14) begin
                n_tests++;
                if ({r_l, g_l, b_l} !== 8'h05) begin
                    n_fail++;
                    $display("FAIL lat3_hcnt10 got %0h exp 05", {r_l, g_l, b_l});
                end
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_small();
        logic [11:0] exp;
        int          last_fs, fs_cnt;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) mem_s[y][x] = 1'($urandom_range(0, 1));
        fg = 8'($urandom);
        bg = 8'($urandom);
        last_fs = -1;
        fs_cnt  = 0;
        pulse_rst_s();
        for (int c = 0; c <= 3 * 84 + 2; c++) begin
            exp = exp_s(c - 2);
            n_tests++;
            if ({r_s, g_s, b_s, blank_s, hs_s, vs_s, fs_s} !== exp) begin
                n_fail++;
                $display("FAIL small_pixel c=%0d got %0h exp %0h", c, {r_s, g_s, b_s, blank_s, hs_s, vs_s, fs_s}, exp);
            end
            if (c >= 10 && c <= 13) begin
                n_tests++;
                if (hs_s !== (c == 11 || c == 12)) begin
                    n_fail++;
                    $display("FAIL small_hs c=%0d got %0b exp %0b", c, hs_s, (c == 11 || c == 12));
                end
            end
            if (fs_s === 1'b1) begin
                if (last_fs >= 0) begin
                    n_tests++;
                    if (c - last_fs !== 84) begin
                        n_fail++;
                        $display("FAIL small_frame_period got %0d exp 84", c - last_fs);
                    end
                end
                last_fs = c;
                fs_cnt++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (fs_cnt !== 4) begin
            n_fail++;
            $display("FAIL small_frame_count got %0d exp 4", fs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_random();
        test_mid_reset();
        test_latency3();
        test_small();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
